link_peer_port: RTL



---
 rtl/link_peer_port.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/link_peer_port.sv
// link_peer_port: far end of the Game Boy serial link cable.
// Exchanges one byte per transfer with the core, either following the core's
// link clock or generating an 8-pulse clock burst itself.
module link_peer_port #(
  parameter logic [15:0] CLK_HALF = 16'd2048,
  parameter logic [23:0] TIMEOUT  = 24'd1048575
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       cfg_master,
  input  logic       link_clk_i,
  output logic       link_clk_o,
  output logic       link_clk_oe,
  input  logic       link_si,
  output logic       link_so,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BYTE_W);
  localparam logic [15:0]      HALF_LAST = CLK_HALF - 16'd1;
  localparam logic [23:0]      WD_LAST   = TIMEOUT - 24'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    F_SHIFT = 2'd1,
    M_LOW   = 2'd2,
    M_HIGH  = 2'd3
  } state_t;

  state_t              state;
  logic                clk_s1, clk_s2, clk_s3;
  logic                si_s1, si_s2;
  logic [BYTE_W-1:0]   hold;
  logic [BYTE_W-1:0]   shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic [15:0]         half_cnt;
  logic [23:0]         wd_cnt;
  logic                m_fall, m_rise;
  logic                hold_valid;
  logic                load_c, fall_c, rise_c;

  // The holding register is full whenever the host side is not ready.
  assign hold_valid = ~tx_ready;
  assign load_c     = tx_valid & tx_ready;
  // Edges are taken between the 2nd and 3rd clock sync stages.
  assign fall_c     = clk_s3 & ~clk_s2;
  assign rise_c     = ~clk_s3 & clk_s2;

  // Two-flop synchronisers for the async link pins, plus an edge-detect stage.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      si_s1  <= 1'b1;
      si_s2  <= 1'b1;
    end else begin
      clk_s1 <= link_clk_i;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      si_s1  <= link_si;
      si_s2  <= si_s1;
    end
  end

  // Holding register, shift engine and link FSM with registered outputs.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hold        <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      half_cnt    <= '0;
      wd_cnt      <= '0;
      m_fall      <= 1'b0;
      m_rise      <= 1'b0;
      link_clk_o  <= 1'b1;
      link_clk_oe <= 1'b0;
      link_so     <= 1'b1;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      timeout_err <= 1'b0;
      m_fall      <= 1'b0;
      m_rise      <= 1'b0;

      // A load only happens into an empty holder, so it never collides
      // with a start event consuming a full one.
      if (load_c) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!cfg_master) begin
            if (fall_c) begin
              shift    <= hold_valid ? hold : 8'hFF;
              link_so  <= hold_valid ? hold[7] : 1'b1;
              if (hold_valid) tx_ready <= 1'b1;
              bit_cnt  <= '0;
              wd_cnt   <= '0;
              busy     <= 1'b1;
              state    <= F_SHIFT;
            end
          end else if (hold_valid) begin
            shift       <= hold;
            tx_ready    <= 1'b1;
            bit_cnt     <= '0;
            half_cnt    <= '0;
            busy        <= 1'b1;
            link_clk_oe <= 1'b1;
            link_clk_o  <= 1'b0;
            m_fall      <= 1'b1;
            state       <= M_LOW;
          end
        end

        F_SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (fall_c | rise_c) begin
            wd_cnt <= '0;
            if (fall_c) link_so <= shift[7];
            if (rise_c) begin
              shift   <= {shift[6:0], si_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (wd_cnt == WD_LAST) begin
            // Abandon the transfer; the consumed byte is not restored.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 24'd1;
          end
        end

        M_LOW: begin
          if (m_fall) link_so <= shift[7];
          if (half_cnt == HALF_LAST) begin
            half_cnt   <= '0;
            link_clk_o <= 1'b1;
            m_rise     <= 1'b1;
            state      <= M_HIGH;
          end else begin
            half_cnt <= half_cnt + 16'd1;
          end
        end

        M_HIGH: begin
          if (m_rise) begin
            shift   <= {shift[6:0], si_s2};
            bit_cnt <= bit_cnt + 4'd1;
          end
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (bit_cnt < LAST_BIT) begin
              link_clk_o <= 1'b0;
              m_fall     <= 1'b1;
              state      <= M_LOW;
            end else begin
              link_clk_oe <= 1'b0;
              rx_data     <= shift;
              rx_valid    <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            half_cnt <= half_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
